// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready receive port among N bursting requesters.
// The port is locked to one owner per burst; released on valid drop or after MAX_BURST beats.
//
// state   | meaning
// IDLE    | no owner; pick the first valid requester at or after ptr
// GRANT   | owner routed to the downstream port; beats counted
// RELEASE | one dead cycle with the port undriven before the next grant
module hs_rr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  input  logic            m_ready,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [PW-1:0]   owner;
  logic [N-1:0]    pick;
  logic            beat;

  always_comb begin
    owner = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) owner = PW'(i);
    end
  end

  // Search upward from ptr, wrapping modulo N; first valid bit wins.
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req_valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Datapath is steered by the registered grant, so a zero grant yields zero outputs.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < N; i++) begin
      m_data = m_data | (req_data[i*DW +: DW] & {DW{grant_q[i]}});
    end
  end

  assign m_valid   = |(req_valid & grant_q);
  assign req_ready = grant_q & {N{m_ready}};
  assign beat      = m_valid & m_ready;
  assign grant     = grant_q;
  assign busy      = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!m_valid || (beat && (cnt_q == CNT_LAST))) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = PW'((int'(owner) + 1) % N);
        end
        if (beat) cnt_d = cnt_q + 8'd1;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Scoreboard bench for hs_rr_arbiter: expected beats queued by stimulus, popped by a monitor.
// Two instances share the inputs; dut_b uses a short MAX_BURST for forced-release cases.
module tb_hs_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic            m_ready;

  logic [N-1:0]  req_ready_a, grant_a, req_ready_b, grant_b;
  logic          m_valid_a, m_valid_b, busy_a, busy_b;
  logic [DW-1:0] m_data_a, m_data_b;

  logic          sel;
  logic [N-1:0]  mon_req_ready, mon_grant;
  logic          mon_m_valid, mon_busy;
  logic [DW-1:0] mon_m_data;

  assign mon_req_ready = sel ? req_ready_b : req_ready_a;
  assign mon_grant     = sel ? grant_b     : grant_a;
  assign mon_m_valid   = sel ? m_valid_b   : m_valid_a;
  assign mon_busy      = sel ? busy_b      : busy_a;
  assign mon_m_data    = sel ? m_data_b    : m_data_a;

  always #5 clk = ~clk;

  hs_rr_arbiter #(.N(N), .DW(DW), .MAX_BURST(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_a), .m_valid(m_valid_a), .m_data(m_data_a),
    .m_ready(m_ready), .grant(grant_a), .busy(busy_a)
  );

  hs_rr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_b), .m_valid(m_valid_b), .m_data(m_data_b),
    .m_ready(m_ready), .grant(grant_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [DW-1:0] d;
  } beat_t;
  beat_t exp_q[$];

  // requester behaviour: left beats in the current burst, extra bursts, one-cycle re-arm
  int            left[N];
  int            bursts[N];
  bit            reload[N];
  logic [DW-1:0] dat[N];
  logic [N-1:0]  noise;
  logic          tgl;
  int            blen;

  logic [N-1:0] tr_g[$];
  logic         tr_r[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      beat_t e;
      check("ready_route", 32'(mon_req_ready), 32'(mon_grant & {N{m_ready}}));
      check("grant_onehot0", 32'($onehot0(mon_grant)), 32'd1);
      if (mon_grant == '0) begin
        check("idle_valid", 32'(mon_m_valid), 32'd0);
        check("idle_data", 32'(mon_m_data), 32'd0);
      end
      if (mon_m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got grant %0h data %0h expected no beat at %0t",
                   mon_grant, mon_m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_grant", 32'(mon_grant), 32'(e.g));
          check("beat_data", 32'(mon_m_data), 32'(e.d));
        end
      end
    end
  end

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (left[i] != 0) | (noise[i] & tgl);
      req_data[i*DW +: DW] = dat[i];
    end
  endtask

  task automatic step(input logic rdy);
    logic [N-1:0] fire;
    bit any;
    m_ready = rdy;
    @(negedge clk);
    fire = req_valid & mon_req_ready;
    @(posedge clk);
    #1;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (reload[i]) begin
        left[i]   = blen;
        reload[i] = 1'b0;
      end else if (fire[i]) begin
        dat[i] = dat[i] + 16'd1;
        if (left[i] > 0) left[i]--;
        if (left[i] == 0 && bursts[i] > 0) begin
          bursts[i]--;
          reload[i] = 1'b1;
        end
      end
      if (left[i] != 0 || reload[i]) any = 1'b1;
    end
    tgl = ~tgl;
    if (!any) noise = '0;
    drive_inputs();
  endtask

  task automatic run_trace();
    for (int k = 0; k < tr_g.size(); k++) begin
      step((k < tr_r.size()) ? tr_r[k] : 1'b1);
      check($sformatf("grant_c%0d", k + 1), 32'(mon_grant), 32'(tr_g[k]));
      check($sformatf("busy_c%0d", k + 1), 32'(mon_busy), 32'(tr_g[k] != '0));
    end
    check("queue_drained", exp_q.size(), 32'd0);
    tr_r = {};
  endtask

  task automatic push_beats(input logic [N-1:0] g, input logic [DW-1:0] start, input int n);
    for (int j = 0; j < n; j++) begin
      beat_t e;
      e.g = g;
      e.d = start + DW'(j);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      left[i]   = 0;
      bursts[i] = 0;
      reload[i] = 1'b0;
      dat[i]    = '0;
    end
    noise = '0;
    tgl   = 1'b0;
    blen  = 0;
  endtask

  task automatic do_reset(input logic s);
    rst_n   = 1'b0;
    sel     = s;
    m_ready = 1'b0;
    clear_reqs();
    drive_inputs();
    exp_q = {};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset values with every input active
    rst_n     = 1'b0;
    sel       = 1'b0;
    m_ready   = 1'b1;
    req_valid = '1;
    req_data  = {N*DW{1'b1}};
    clear_reqs();
    #2;
    check("rst_grant", 32'(grant_a), 32'd0);
    check("rst_m_valid", 32'(m_valid_a), 32'd0);
    check("rst_m_data", 32'(m_data_a), 32'd0);
    check("rst_req_ready", 32'(req_ready_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);

    // single requester burst
    do_reset(1'b0);
    left[0] = 5;
    dat[0]  = 16'h1000;
    drive_inputs();
    push_beats(4'b0001, 16'h1000, 5);
    tr_g = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    run_trace();

    // round-robin fairness, requester 0 comes back for a second burst
    do_reset(1'b0);
    blen = 2;
    for (int i = 0; i < N; i++) begin
      left[i] = 2;
      dat[i]  = DW'(i * 16'h1000 + 16'h0100);
    end
    bursts[0] = 1;
    drive_inputs();
    push_beats(4'b0001, 16'h0100, 2);
    push_beats(4'b0010, 16'h1100, 2);
    push_beats(4'b0100, 16'h2100, 2);
    push_beats(4'b1000, 16'h3100, 2);
    push_beats(4'b0001, 16'h0102, 2);
    tr_g = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
             4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0,
             4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    run_trace();

    // forced release at MAX_BURST=4, requester 2 regranted since 3 is idle
    do_reset(1'b1);
    left[2] = 10;
    dat[2]  = 16'h2000;
    drive_inputs();
    push_beats(4'b0100, 16'h2000, 10);
    tr_g = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
             4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    run_trace();

    // backpressure: stalled cycles must not count toward MAX_BURST=4
    do_reset(1'b1);
    left[1] = 5;
    dat[1]  = 16'h6000;
    drive_inputs();
    push_beats(4'b0010, 16'h6000, 5);
    tr_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tr_g = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
    run_trace();

    // async reset during beat 3 of requester 0
    do_reset(1'b0);
    left[0] = 5;
    dat[0]  = 16'h4000;
    drive_inputs();
    push_beats(4'b0001, 16'h4000, 2);
    repeat (3) step(1'b1);
    check("pre_rst_valid", 32'(m_valid_a), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant_a), 32'd0);
    check("async_m_valid", 32'(m_valid_a), 32'd0);
    check("async_req_ready", 32'(req_ready_a), 32'd0);
    check("async_busy", 32'(busy_a), 32'd0);
    check("async_dropped", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    clear_reqs();
    left[0] = 1;
    dat[0]  = 16'h5000;
    left[1] = 1;
    dat[1]  = 16'h5100;
    drive_inputs();
    rst_n = 1'b1;
    push_beats(4'b0001, 16'h5000, 1);
    push_beats(4'b0010, 16'h5100, 1);
    tr_g = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
    run_trace();

    // non-owner noise on requester 3 during requester 1's burst
    do_reset(1'b0);
    left[1]  = 4;
    dat[1]   = 16'h7000;
    dat[3]   = 16'hDEAD;
    noise[3] = 1'b1;
    drive_inputs();
    push_beats(4'b0010, 16'h7000, 4);
    tr_g = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    run_trace();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
